// File: rtl/tcp_tx_axis_reader_pkg.sv
// Shared constants and types for the TCP TX packet-buffer read side.
// The RAM word is packed as {last, keep, data}.
package tcp_tx_pkg;

   localparam int DATA_BITS_DEF = 512;
   localparam int KEEP_BITS_DEF = DATA_BITS_DEF / 8;

   function automatic int last_bit_pos(input int data_bits, input int keep_bits);
      return data_bits + keep_bits;
   endfunction

   localparam int LAST_BIT = last_bit_pos(DATA_BITS_DEF, KEEP_BITS_DEF);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } tx_state_e;

endpackage

// File: rtl/tcp_tx_axis_reader_if.sv
// Write-side (segment builder) and AXI-Stream (MAC side) bundles of the TX buffer reader.
// The write bundle also carries the buffer status flags back to the builder.
interface tcp_tx_wr_if
   import tcp_tx_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int KEEP_BITS = DATA_BITS / 8,
   parameter int ADDR_BITS = 10
);
   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic [KEEP_BITS-1:0] wr_keep;
   logic                 wr_last;
   logic                 full;
   logic                 empty;
   logic                 overflow;
   logic [ADDR_BITS:0]   occupancy;
   logic [ADDR_BITS:0]   pkt_count;

   modport master (
      output wr_en, wr_data, wr_keep, wr_last,
      input  full, empty, overflow, occupancy, pkt_count
   );

   modport slave (
      input  wr_en, wr_data, wr_keep, wr_last,
      output full, empty, overflow, occupancy, pkt_count
   );
endinterface

interface tcp_tx_axis_if
   import tcp_tx_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int KEEP_BITS = DATA_BITS / 8
);
   logic [DATA_BITS-1:0] m_axis_tdata;
   logic [KEEP_BITS-1:0] m_axis_tkeep;
   logic                 m_axis_tlast;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready;

   modport master (
      output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      input  m_axis_tready
   );

   modport slave (
      input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      output m_axis_tready
   );
endinterface

// File: rtl/tcp_tx_axis_reader_skid.sv
// Two-entry output skid buffer; the head entry drives the stream and only
// changes on a handoff, so downstream sees stable data while stalled.
module tcp_tx_skid_reg #(
   parameter int WIDTH = 577
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [WIDTH-1:0] s_data_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic [1:0]       count_o
);
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             push, pop;

   assign s_ready_o = (cnt_q != 2'd2);
   assign m_valid_o = (cnt_q != 2'd0);
   assign m_data_o  = head_q;
   assign count_o   = cnt_q;
   assign push      = s_valid_i && s_ready_o;
   assign pop       = m_valid_o && m_ready_i;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = s_data_i;
            else               tail_d = s_data_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // Push and pop together: the new beat lands behind whatever remains.
            if (cnt_q == 2'd1) begin
               head_d = s_data_i;
            end else begin
               head_d = tail_q;
               tail_d = s_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/tcp_tx_axis_reader.sv
// Store-and-forward drain of the TCP TX circular beat buffer onto AXI-Stream:
// a packet is only read out once its last beat is resident in the RAM.
module tcp_tx_axis_reader
   import tcp_tx_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int KEEP_BITS = DATA_BITS / 8,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           resetn,
   tcp_tx_wr_if.slave    wr,
   tcp_tx_axis_if.master m_axis
);
   localparam int                   LAST_POS  = last_bit_pos(DATA_BITS, KEEP_BITS);
   localparam int                   WORD_BITS = LAST_POS + 1;
   localparam logic [0:0]           ST_IDLE   = IDLE;
   localparam logic [0:0]           ST_STREAM = STREAM;
   localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS + 1)'(1);
   localparam logic [ADDR_BITS:0]   CNT_FULL  = (ADDR_BITS + 1)'(DEPTH);
   localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

   logic [WORD_BITS-1:0] mem      [DEPTH];
   logic                 last_mem [DEPTH];
   logic [WORD_BITS-1:0] rd_word_q;
   logic [WORD_BITS-1:0] out_word;

   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   occ_q, occ_d, pkt_q, pkt_d;
   logic [ADDR_BITS:0]   ucnt_q, ucnt_d, pend_q, pend_d;
   logic                 overflow_q, overflow_d, rd_valid_q, rd_valid_d;
   logic [0:0]           state_q, state_d;

   logic                 full_w, wr_acc, handoff, rd_issue, issue_last, skid_in_ready;
   logic [1:0]           skid_cnt;
   logic [2:0]           slots_used;

   function automatic logic [ADDR_BITS:0] bump(input logic [ADDR_BITS:0] cnt,
                                              input logic inc, input logic dec);
      case ({inc, dec})
         2'b10:   return cnt + CNT_ONE;
         2'b01:   return cnt - CNT_ONE;
         default: return cnt;
      endcase
   endfunction

   assign full_w     = (occ_q == CNT_FULL);
   assign wr_acc     = wr.wr_en && !full_w;
   assign handoff    = m_axis.m_axis_tvalid && m_axis.m_axis_tready;
   // A read issued now lands in the skid next cycle, so count the slot a handoff frees now.
   assign slots_used = {1'b0, skid_cnt} + {2'b00, rd_valid_q};
   assign rd_issue   = (state_q == ST_STREAM) && (ucnt_q != '0) &&
                       ((slots_used < 3'd2) || (handoff && (slots_used < 3'd3)));
   assign issue_last = rd_issue && last_mem[rd_ptr_q];

   assign wr.full      = full_w;
   assign wr.empty     = (occ_q == '0);
   assign wr.overflow  = overflow_q;
   assign wr.occupancy = occ_q;
   assign wr.pkt_count = pkt_q;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q]      <= {wr.wr_last, wr.wr_keep, wr.wr_data};
         last_mem[wr_ptr_q] <= wr.wr_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_issue) rd_word_q <= mem[rd_ptr_q];
   end

   always_comb begin
      wr_ptr_d   = wr_acc   ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = rd_issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      occ_d      = bump(occ_q,  wr_acc, handoff);
      pkt_d      = bump(pkt_q,  wr_acc && wr.wr_last, handoff && m_axis.m_axis_tlast);
      ucnt_d     = bump(ucnt_q, wr_acc, rd_issue);
      pend_d     = bump(pend_q, wr_acc && wr.wr_last, issue_last);
      overflow_d = overflow_q || (wr.wr_en && full_w);
      rd_valid_d = rd_issue || (rd_valid_q && !skid_in_ready);
      state_d    = state_q;
      // Looking at the next pending count lets a just-completed packet start a cycle earlier.
      case (state_q)
         ST_IDLE:   if (pend_d != '0) state_d = ST_STREAM;
         ST_STREAM: if (issue_last && (pend_d == '0)) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         pkt_q      <= '0;
         ucnt_q     <= '0;
         pend_q     <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         state_q    <= ST_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         pkt_q      <= pkt_d;
         ucnt_q     <= ucnt_d;
         pend_q     <= pend_d;
         overflow_q <= overflow_d;
         rd_valid_q <= rd_valid_d;
         state_q    <= state_d;
      end
   end

   tcp_tx_skid_reg #(
      .WIDTH (WORD_BITS)
   ) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .s_valid_i (rd_valid_q),
      .s_ready_o (skid_in_ready),
      .s_data_i  (rd_word_q),
      .m_valid_o (m_axis.m_axis_tvalid),
      .m_ready_i (m_axis.m_axis_tready),
      .m_data_o  (out_word),
      .count_o   (skid_cnt)
   );

   assign {m_axis.m_axis_tlast, m_axis.m_axis_tkeep, m_axis.m_axis_tdata} = out_word;

endmodule

// File: tb/tb_tcp_tx_axis_reader.sv
// Scoreboard bench for tcp_tx_axis_reader: every accepted write pushes its expected
// beat, and a negedge monitor compares whatever the DUT presents on the stream.
module tb_tcp_tx_axis_reader;
   import tcp_tx_pkg::*;

   localparam int DEPTH     = 1024;
   localparam int DATA_BITS = 512;
   localparam int KEEP_BITS = 64;
   localparam int ADDR_BITS = 10;
   localparam int WORD_BITS = DATA_BITS + KEEP_BITS + 1;

   logic clk;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;
   bit   prevStall;
   logic [WORD_BITS-1:0] expQ[$];

   tcp_tx_wr_if #(.DATA_BITS(DATA_BITS), .KEEP_BITS(KEEP_BITS), .ADDR_BITS(ADDR_BITS)) wrIf();
   tcp_tx_axis_if #(.DATA_BITS(DATA_BITS), .KEEP_BITS(KEEP_BITS)) axIf();

   tcp_tx_axis_reader #(
      .DEPTH     (DEPTH),
      .DATA_BITS (DATA_BITS),
      .KEEP_BITS (KEEP_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .wr     (wrIf),
      .m_axis (axIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WORD_BITS-1:0] makeWord(input logic [31:0] tag, input logic last);
      logic [DATA_BITS-1:0] d;
      logic [KEEP_BITS-1:0] k;
      d = {(DATA_BITS / 32){tag}};
      k = {32'hFFFF_FFFF, tag};
      return {last, k, d};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkBeat();
      logic [WORD_BITS-1:0] act;
      logic [WORD_BITS-1:0] exp;
      act = {axIf.m_axis_tlast, axIf.m_axis_tkeep, axIf.m_axis_tdata};
      exp = expQ[0];
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL beat: got tag=%0h keep=%h last=%b expected tag=%0h keep=%h last=%b at %0t",
                  act[31:0], act[DATA_BITS +: KEEP_BITS], act[WORD_BITS-1],
                  exp[31:0], exp[DATA_BITS +: KEEP_BITS], exp[WORD_BITS-1], $time);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] tag, input logic last, input bit expectAccept);
      wrIf.wr_en   = 1'b1;
      wrIf.wr_data = {(DATA_BITS / 32){tag}};
      wrIf.wr_keep = {32'hFFFF_FFFF, tag};
      wrIf.wr_last = last;
      if (expectAccept) expQ.push_back(makeWord(tag, last));
      @(posedge clk);
      #1;
      wrIf.wr_en = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitDrain(input string name, input int bound);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, 64'(expQ.size()), 64'd0);
   endtask

   // Monitor: compare the presented beat with the scoreboard head, pop on handoff.
   always @(negedge clk) begin
      if (!resetn) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) checkOutput("tvalid_hold", 64'(axIf.m_axis_tvalid), 64'd1);
         if (axIf.m_axis_tvalid) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_beat: got tag %0h with no beat expected at %0t",
                        axIf.m_axis_tdata[31:0], $time);
            end else begin
               checkBeat();
               if (axIf.m_axis_tready) expQ.delete(0);
            end
         end
         prevStall = axIf.m_axis_tvalid && !axIf.m_axis_tready;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit pat[4];
      int i;
      bit found;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      resetn            = 1'b0;
      wrIf.wr_en        = 1'b0;
      wrIf.wr_data      = '0;
      wrIf.wr_keep      = '0;
      wrIf.wr_last      = 1'b0;
      axIf.m_axis_tready = 1'b0;

      #12;
      checkOutput("rst_tvalid",   64'(axIf.m_axis_tvalid), 64'd0);
      checkOutput("rst_tlast",    64'(axIf.m_axis_tlast), 64'd0);
      checkOutput("rst_tdata",    axIf.m_axis_tdata[63:0], 64'd0);
      checkOutput("rst_tkeep",    axIf.m_axis_tkeep, 64'd0);
      checkOutput("rst_occ",      64'(wrIf.occupancy), 64'd0);
      checkOutput("rst_pkt",      64'(wrIf.pkt_count), 64'd0);
      checkOutput("rst_empty",    64'(wrIf.empty), 64'd1);
      checkOutput("rst_full",     64'(wrIf.full), 64'd0);
      checkOutput("rst_overflow", 64'(wrIf.overflow), 64'd0);
      #11;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single packet latency");
      axIf.m_axis_tready = 1'b1;
      applyStimulus(32'd1, 1'b0, 1'b1);
      applyStimulus(32'd2, 1'b0, 1'b1);
      applyStimulus(32'd3, 1'b1, 1'b1);
      checkOutput("t1_occ",       64'(wrIf.occupancy), 64'd3);
      checkOutput("t1_pkt",       64'(wrIf.pkt_count), 64'd1);
      checkOutput("t1_tvalid_k0", 64'(axIf.m_axis_tvalid), 64'd0);
      idleCycles(1);
      checkOutput("t1_tvalid_k1", 64'(axIf.m_axis_tvalid), 64'd0);
      idleCycles(1);
      checkOutput("t1_tvalid_k2", 64'(axIf.m_axis_tvalid), 64'd1);
      checkOutput("t1_first_tag", 64'(axIf.m_axis_tdata[31:0]), 64'd1);
      idleCycles(1);
      checkOutput("t1_tvalid_k3", 64'(axIf.m_axis_tvalid), 64'd1);
      checkOutput("t1_tlast_k3",  64'(axIf.m_axis_tlast), 64'd0);
      idleCycles(1);
      checkOutput("t1_tvalid_k4", 64'(axIf.m_axis_tvalid), 64'd1);
      checkOutput("t1_tlast_k4",  64'(axIf.m_axis_tlast), 64'd1);
      idleCycles(1);
      checkOutput("t1_tvalid_k5", 64'(axIf.m_axis_tvalid), 64'd0);
      checkOutput("t1_occ_done",  64'(wrIf.occupancy), 64'd0);
      checkOutput("t1_empty",     64'(wrIf.empty), 64'd1);
      waitDrain("t1_drain", 10);

      $display("[TB] store-and-forward hold");
      applyStimulus(32'd10, 1'b0, 1'b1);
      applyStimulus(32'd11, 1'b0, 1'b1);
      for (int c = 0; c < 20; c++) begin
         idleCycles(1);
         checkOutput("t2_hold_tvalid", 64'(axIf.m_axis_tvalid), 64'd0);
      end
      checkOutput("t2_occ", 64'(wrIf.occupancy), 64'd2);
      checkOutput("t2_pkt", 64'(wrIf.pkt_count), 64'd0);
      applyStimulus(32'd12, 1'b1, 1'b1);
      checkOutput("t2_tvalid_k0", 64'(axIf.m_axis_tvalid), 64'd0);
      idleCycles(1);
      checkOutput("t2_tvalid_k1", 64'(axIf.m_axis_tvalid), 64'd0);
      idleCycles(1);
      checkOutput("t2_tvalid_k2", 64'(axIf.m_axis_tvalid), 64'd1);
      checkOutput("t2_first_tag", 64'(axIf.m_axis_tdata[31:0]), 64'd10);
      waitDrain("t2_drain", 20);

      $display("[TB] backpressure");
      axIf.m_axis_tready = 1'b0;
      for (int b = 0; b < 8; b++) applyStimulus(32'(20 + b), (b == 7), 1'b1);
      checkOutput("t3_pkt_start", 64'(wrIf.pkt_count), 64'd1);
      checkOutput("t3_occ_start", 64'(wrIf.occupancy), 64'd8);
      i = 0;
      while (expQ.size() != 0 && i < 100) begin
         axIf.m_axis_tready = pat[i % 4];
         @(posedge clk);
         #1;
         checkOutput("t3_pkt_track", 64'(wrIf.pkt_count), (expQ.size() != 0) ? 64'd1 : 64'd0);
         i++;
      end
      checkOutput("t3_drain", 64'(expQ.size()), 64'd0);
      checkOutput("t3_empty", 64'(wrIf.empty), 64'd1);
      axIf.m_axis_tready = 1'b1;
      idleCycles(2);

      $display("[TB] full and overflow");
      axIf.m_axis_tready = 1'b0;
      for (int b = 0; b < DEPTH; b++) applyStimulus(32'(1000 + b), (b == DEPTH - 1), 1'b1);
      checkOutput("t4_full",     64'(wrIf.full), 64'd1);
      checkOutput("t4_occ_full", 64'(wrIf.occupancy), 64'd1024);
      checkOutput("t4_pkt",      64'(wrIf.pkt_count), 64'd1);
      checkOutput("t4_ovf_pre",  64'(wrIf.overflow), 64'd0);
      applyStimulus(32'd9999, 1'b1, 1'b0);
      checkOutput("t4_ovf_set",  64'(wrIf.overflow), 64'd1);
      checkOutput("t4_occ_drop", 64'(wrIf.occupancy), 64'd1024);
      checkOutput("t4_pkt_drop", 64'(wrIf.pkt_count), 64'd1);
      axIf.m_axis_tready = 1'b1;
      waitDrain("t4_drain", 1200);
      idleCycles(1);
      checkOutput("t4_empty",     64'(wrIf.empty), 64'd1);
      checkOutput("t4_full_clr",  64'(wrIf.full), 64'd0);
      checkOutput("t4_ovf_stick", 64'(wrIf.overflow), 64'd1);

      $display("[TB] concurrent single-beat packets");
      for (int b = 0; b < 40; b++) begin
         applyStimulus(32'(3000 + b), 1'b1, 1'b1);
         if (b >= 2) begin
            checkOutput("t5_occ_range", 64'((wrIf.occupancy == 11'd2) || (wrIf.occupancy == 11'd3)), 64'd1);
            checkOutput("t5_pkt_bound", 64'(wrIf.pkt_count <= 11'd3), 64'd1);
         end
      end
      waitDrain("t5_drain", 20);
      idleCycles(1);
      checkOutput("t5_empty", 64'(wrIf.empty), 64'd1);

      $display("[TB] reset mid-packet");
      for (int b = 0; b < 6; b++) applyStimulus(32'(4000 + b), (b == 5), 1'b1);
      found = 1'b0;
      i = 0;
      while (!found && i < 20) begin
         @(posedge clk);
         #1;
         if (axIf.m_axis_tvalid && (axIf.m_axis_tdata[31:0] == 32'd4002)) found = 1'b1;
         i++;
      end
      checkOutput("t6_beat3_seen", 64'(found), 64'd1);
      #2;
      resetn = 1'b0;
      expQ.delete();
      #1;
      checkOutput("t6_tvalid",   64'(axIf.m_axis_tvalid), 64'd0);
      checkOutput("t6_tlast",    64'(axIf.m_axis_tlast), 64'd0);
      checkOutput("t6_occ",      64'(wrIf.occupancy), 64'd0);
      checkOutput("t6_pkt",      64'(wrIf.pkt_count), 64'd0);
      checkOutput("t6_overflow", 64'(wrIf.overflow), 64'd0);
      checkOutput("t6_empty",    64'(wrIf.empty), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #3;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(32'd5000, 1'b0, 1'b1);
      applyStimulus(32'd5001, 1'b0, 1'b1);
      applyStimulus(32'd5002, 1'b1, 1'b1);
      idleCycles(1);
      checkOutput("t6_new_tvalid_k1", 64'(axIf.m_axis_tvalid), 64'd0);
      idleCycles(1);
      checkOutput("t6_new_tvalid_k2", 64'(axIf.m_axis_tvalid), 64'd1);
      checkOutput("t6_new_first_tag", 64'(axIf.m_axis_tdata[31:0]), 64'd5000);
      waitDrain("t6_drain", 20);
      idleCycles(1);
      checkOutput("t6_end_empty", 64'(wrIf.empty), 64'd1);
      checkOutput("t6_end_pkt",   64'(wrIf.pkt_count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tcp_tx_axis_reader.md
Name: tcp_tx_axis_reader

Overview:
Read side of the TCP TX packet buffer. The segment builder writes 512-bit beats, each with keep and last flags, into a circular RAM. This block drains the RAM onto an AXI-Stream master toward the MAC/PHY. It operates in store-and-forward mode, so a packet is only launched once its last beat is resident, and no underrun can occur mid-frame.

Parameters:
DEPTH, 1024, buffer entries in beats; power of 2, at least 4.
DATA_BITS, 512, beat width.
KEEP_BITS, DATA_BITS/8, byte-enable width.
ADDR_BITS, clog2(DEPTH), pointer width.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
wr_en  in  1  write strobe from segment builder
wr_data  in  DATA_BITS  beat data
wr_keep  in  KEEP_BITS  byte enables of the beat
wr_last  in  1  beat ends a packet
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
overflow  out  1  sticky; a write was dropped
occupancy  out  ADDR_BITS+1  beats held, including the output pipeline
pkt_count  out  ADDR_BITS+1  complete packets held
m_axis_tdata  out  DATA_BITS  stream data
m_axis_tkeep  out  KEEP_BITS  stream byte enables
m_axis_tlast  out  1  stream end of packet
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready

Behaviour:
- Reset: asynchronous, active-low.
  - Pointers, occupancy, pkt_count, overflow, tvalid, tlast and FSM state clear immediately.
  - tdata and tkeep reset to 0.
  - RAM contents are not cleared.
  - A packet in flight is abandoned; no tlast is emitted.
- RAM word = {last, keep, data}.
- Write rules:
  - A write is accepted when wr_en=1 and full=0, into mem[wr_ptr]; wr_ptr then increments modulo DEPTH.
  - wr_en=1 while full=1: the beat is dropped, no state changes, and overflow is set. overflow clears only on reset.
- Occupancy rules:
  - occupancy counts beats accepted minus beats handed off on the AXIS port (tvalid & tready).
  - An accepted write and a handoff in the same cycle leave occupancy unchanged.
  - full is asserted at occupancy == DEPTH (the full DEPTH is usable).
- pkt_count rules:
  - +1 on an accepted write with wr_last=1.
  - -1 on a handoff with tlast=1.
  - Both in the same cycle: unchanged.
- Read pipeline:
  - The RAM is a synchronous 1-cycle read, followed by a 2-entry output skid register.
  - A read is issued only when: the RAM holds unissued beats, the FSM is in STREAM, and the skid has a free slot after accounting for in-flight reads.
  - rd_ptr wraps modulo DEPTH.
- FSM states:
  - IDLE: no read issue. Go to STREAM when pkt_count > 0 (counting packets not yet fully issued).
  - STREAM: issue reads every eligible cycle. When the issued beat carries last=1, return to IDLE if no further complete packet is unissued; otherwise stay in STREAM. Back-to-back packets have no gap.
- Latency: a last beat accepted at edge k into an otherwise empty buffer gives tvalid=1 after edge k+2, with the first beat of that packet on the port.
- Throughput: with tready held at 1, one beat per cycle is sustained indefinitely.
- AXIS rules:
  - Once tvalid is asserted, tdata, tkeep and tlast are held stable until tready is seen.
  - tvalid never drops without a handoff.
- Simultaneous write and read at the same address is impossible by construction: occupancy < DEPTH is required to write.

Decomposition:
- Package tcp_tx_pkg: DATA_BITS and KEEP_BITS defaults, the RAM word packing constant LAST_BIT, and the FSM state enum {IDLE, STREAM}.
- One sub-module: tcp_tx_skid_reg, a 2-entry AXIS output skid buffer with valid/ready on both sides.
- RAM inferred inline.

Test Plan:
- Single packet: write 3 beats into the empty buffer, the 3rd with wr_last=1, tready=1 -> tvalid rises 2 cycles after the 3rd write; 3 consecutive beats come out with tlast only on beat 3; occupancy returns to 0.
- Store-and-forward hold: write 2 beats without last and wait 20 cycles -> tvalid stays 0; write the last beat -> streaming starts 2 cycles later.
- Backpressure: 8-beat packet, tready toggling 1,0,0,1 -> data is stable while stalled; beat order is 0..7 with no loss or duplication; pkt_count goes 1 -> 0 on beat 7.
- Full/overflow: tready=0, write DEPTH=1024 beats ending in last -> full=1, occupancy=1024; an extra write is dropped and overflow=1; then tready=1 -> all 1024 beats are read in order across the pointer wrap.
- Concurrent: continuous 1-beat packets written every cycle with tready=1 -> one beat out per cycle, occupancy steady at 2 or 3, pkt_count bounded.
- Reset mid-packet: assert resetn=0 asynchronously between clock edges during beat 3 of 6 -> tvalid falls immediately and all counters read 0; after release, a new packet streams correctly.
